// File: rtl/keccak_seq_pkg.sv
// Shared encodings for the Keccak round sequencer: FSM states, lane-memory
// owner codes and the fixed engine order of one permutation round.
package keccak_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    ADVANCE = 3'd3,
    FINISH  = 3'd4,
    FAULT   = 3'd5
  } seqState_e;

  // Lane-memory owner: the host owns it at 0, engine k owns it at k+1.
  localparam logic [2:0] MEM_HOST = 3'd0;

  localparam int THETA = 0;
  localparam int RHO   = 1;
  localparam int PI    = 2;
  localparam int CHI   = 3;
  localparam int IOTA  = 4;

  localparam int ROUNDS_DEFAULT = 24;

endpackage

// File: rtl/step_watchdog.sv
// Per-step timeout counter: counts enabled cycles, saturates at all-ones and
// flags the enabled cycle whose increment reaches that terminal count.
module step_watchdog #(
  parameter int WDW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam logic [WDW-1:0] TERM_CNT = {WDW{1'b1}};

  logic [WDW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != TERM_CNT)) begin
      count <= count + WDW'(1);
    end
  end

  // Asserted one cycle early so the FSM leaves WAIT on the very edge the
  // count reaches its terminal value.
  assign terminal = en && (count == (TERM_CNT - WDW'(1)));

endmodule

// File: rtl/keccak_round_sequencer.sv
// Round/step scheduler for the Keccak permutation: launches the step engines
// in order for ROUNDS rounds and arbitrates ownership of the shared lane memory.
module keccak_round_sequencer
  import keccak_seq_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT,
  parameter int NSTEPS = 5,
  parameter int RW     = 5,
  parameter int WDW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NSTEPS-1:0] step_done,
  output logic [NSTEPS-1:0] step_start,
  output logic [2:0]        mem_sel,
  output logic [RW-1:0]     round_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int SW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [NSTEPS-1:0] LAUNCH_ONE = NSTEPS'(1);

  seqState_e         state, stateNxt;
  logic [SW-1:0]     stepQ, stepNxt;
  logic [RW-1:0]     roundNxt;
  logic [NSTEPS-1:0] stepStartNxt;
  logic [2:0]        memSelNxt;
  logic              busyNxt, doneNxt, errorNxt;
  logic              wdClr, wdEn, wdTerminal;
  logic              stepAck, lastStep, lastRound;

  // Only the engine currently launched may complete the step.
  assign stepAck   = step_done[stepQ];
  assign lastStep  = (int'(stepQ) >= NSTEPS - 1);
  assign lastRound = (int'(round_idx) >= ROUNDS - 1);

  assign wdEn  = (state == WAIT);
  assign wdClr = (state != WAIT);

  step_watchdog #(
    .WDW(WDW)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (wdClr),
    .en       (wdEn),
    .terminal (wdTerminal)
  );

  always_comb begin
    stateNxt = state;
    stepNxt  = stepQ;
    roundNxt = round_idx;

    case (state)
      IDLE: begin
        if (start) begin
          stateNxt = LAUNCH;
          stepNxt  = SW'(THETA);
          roundNxt = '0;
        end
      end
      LAUNCH: stateNxt = WAIT;
      WAIT: begin
        if (stepAck) begin
          stateNxt = ADVANCE;
        end else if (wdTerminal) begin
          stateNxt = FAULT;
        end
      end
      ADVANCE: begin
        if (!lastStep) begin
          stepNxt  = stepQ + SW'(1);
          stateNxt = LAUNCH;
        end else if (!lastRound) begin
          roundNxt = round_idx + RW'(1);
          stepNxt  = '0;
          stateNxt = LAUNCH;
        end else begin
          stateNxt = FINISH;
        end
      end
      FINISH: stateNxt = IDLE;
      FAULT: begin
        if (start) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase

    // Abort outranks engine completion and the watchdog for an active run.
    if (abort && (state != IDLE) && (state != FAULT)) begin
      stateNxt = IDLE;
    end

    if (stateNxt == IDLE) begin
      stepNxt  = '0;
      roundNxt = '0;
    end

    // Outputs are decoded from the next state so they register with it.
    stepStartNxt = (stateNxt == LAUNCH) ? (LAUNCH_ONE << stepNxt) : '0;
    memSelNxt    = (stateNxt inside {LAUNCH, WAIT, ADVANCE}) ? (3'(stepNxt) + 3'd1) : MEM_HOST;
    busyNxt      = (stateNxt inside {LAUNCH, WAIT, ADVANCE, FINISH});
    doneNxt      = (stateNxt == FINISH);
    errorNxt     = (stateNxt == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stepQ      <= '0;
      round_idx  <= '0;
      step_start <= '0;
      mem_sel    <= MEM_HOST;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= stateNxt;
      stepQ      <= stepNxt;
      round_idx  <= roundNxt;
      step_start <= stepStartNxt;
      mem_sel    <= memSelNxt;
      busy       <= busyNxt;
      done       <= doneNxt;
      error      <= errorNxt;
    end
  end

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Bench for keccak_round_sequencer: table of engine-latency runs checked
// through an event scoreboard, plus hand-written abort/fault/reset sequences.
module tb_keccak_round_sequencer;

  localparam int ROUNDS = 2;
  localparam int NSTEPS = 5;
  localparam int RW     = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              startA, abortA, startB, abortB;
  logic [NSTEPS-1:0] stepDoneA, stepDoneB;
  logic [NSTEPS-1:0] stepStartA, stepStartB;
  logic [2:0]        memSelA, memSelB;
  logic [RW-1:0]     roundIdxA, roundIdxB;
  logic              busyA, doneA, errorA, busyB, doneB, errorB;

  keccak_round_sequencer #(.ROUNDS(ROUNDS), .NSTEPS(NSTEPS), .RW(RW), .WDW(8)) dutA (
    .clk(clk), .rst(rst), .start(startA), .abort(abortA), .step_done(stepDoneA),
    .step_start(stepStartA), .mem_sel(memSelA), .round_idx(roundIdxA),
    .busy(busyA), .done(doneA), .error(errorA)
  );

  keccak_round_sequencer #(.ROUNDS(ROUNDS), .NSTEPS(NSTEPS), .RW(RW), .WDW(4)) dutB (
    .clk(clk), .rst(rst), .start(startB), .abort(abortB), .step_done(stepDoneB),
    .step_start(stepStartB), .mem_sel(memSelB), .round_idx(roundIdxB),
    .busy(busyB), .done(doneB), .error(errorB)
  );

  typedef struct {
    int              cyc;
    logic [4:0]      startVec;
    logic            isDone;
    logic [RW-1:0]   round;
    logic [2:0]      memSel;
  } sbEv_t;

  typedef struct {
    logic [NSTEPS-1:0][7:0] dly;
    int                     strayCyc;
    logic [4:0]             strayMask;
    int                     restartCyc;
    int                     expDone;
  } runVec_t;

  sbEv_t      sbq[$];
  runVec_t    tbl[5];
  logic [7:0] curDly [NSTEPS];
  int         pendA [NSTEPS];
  int         cyc, nVec, nFail, doneCyc, memSel2Cnt, strayCyc;
  logic [4:0] strayMask, prevStartB;
  bit         monOn;

  function automatic runVec_t mk(input int d0, input int d1, input int d2, input int d3,
                                 input int d4, input int sc, input logic [4:0] sm,
                                 input int rc, input int ed);
    runVec_t r;
    r.dly[0] = 8'(d0); r.dly[1] = 8'(d1); r.dly[2] = 8'(d2);
    r.dly[3] = 8'(d3); r.dly[4] = 8'(d4);
    r.strayCyc = sc; r.strayMask = sm; r.restartCyc = rc; r.expDone = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, score any launch or
  // done event, then drive the engine models for the new cycle.
  task automatic tick();
    sbEv_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (monOn && ((stepStartA != '0) || doneA)) begin
      if (sbq.size() == 0) begin
        nVec++;
        nFail++;
        $display("FAIL unexpected_event at cycle %0d: step_start=%b done=%b, required no event",
                 cyc, stepStartA, doneA);
      end else begin
        e = sbq.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_step_start", int'(stepStartA), int'(e.startVec));
        chk("event_done", int'(doneA), int'(e.isDone));
        chk("event_round_idx", int'(roundIdxA), int'(e.round));
        chk("event_mem_sel", int'(memSelA), int'(e.memSel));
        chk("event_busy", int'(busyA), 1);
      end
      if (doneA) doneCyc = cyc;
    end
    if (memSelA == 3'd2) memSel2Cnt++;
    stepDoneA = (cyc == strayCyc) ? strayMask : '0;
    for (int k = 0; k < NSTEPS; k++) begin
      if (pendA[k] == cyc) begin
        stepDoneA[k] = 1'b1;
        pendA[k] = -1;
      end
    end
    for (int k = 0; k < NSTEPS; k++) begin
      if (stepStartA[k]) pendA[k] = cyc + int'(curDly[k]);
    end
    // Engine 3 of dutB never answers; the others answer one cycle after launch.
    stepDoneB  = prevStartB & 5'b10111;
    prevStartB = stepStartB;
  endtask

  task automatic clearModels();
    for (int k = 0; k < NSTEPS; k++) pendA[k] = -1;
    stepDoneA = '0;
  endtask

  task automatic doReset();
    monOn = 0;
    rst = 1'b1;
    startA = 1'b0; abortA = 1'b0; startB = 1'b0; abortB = 1'b0;
    tick();
    tick();
    chk("rst_step_start_a", int'(stepStartA), 0);
    chk("rst_mem_sel_a", int'(memSelA), 0);
    chk("rst_round_idx_a", int'(roundIdxA), 0);
    chk("rst_busy_a", int'(busyA), 0);
    chk("rst_done_a", int'(doneA), 0);
    chk("rst_error_a", int'(errorA), 0);
    chk("rst_busy_b", int'(busyB), 0);
    chk("rst_error_b", int'(errorB), 0);
    rst = 1'b0;
    sbq.delete();
    clearModels();
    stepDoneB = '0; prevStartB = '0;
    strayCyc = -1; strayMask = '0;
    monOn = 1;
  endtask

  task automatic setDly(input int d0, input int d1, input int d2, input int d3, input int d4);
    curDly[0] = 8'(d0); curDly[1] = 8'(d1); curDly[2] = 8'(d2);
    curDly[3] = 8'(d3); curDly[4] = 8'(d4);
  endtask

  task automatic beginRun();
    cyc = 0;
    doneCyc = -1;
    memSel2Cnt = 0;
    clearModels();
  endtask

  // Expected launch/done events from the engine latencies: each step costs
  // LAUNCH + (latency) WAIT cycles + ADVANCE.
  task automatic pushRun(input int nLaunch, input bit withDone);
    sbEv_t e;
    int t, k;
    t = 1;
    for (int j = 0; j < nLaunch; j++) begin
      k = j % NSTEPS;
      e.cyc = t; e.startVec = 5'(1 << k); e.isDone = 1'b0;
      e.round = RW'(j / NSTEPS); e.memSel = 3'(k + 1);
      sbq.push_back(e);
      t += int'(curDly[k]) + 2;
    end
    if (withDone) begin
      e.cyc = t; e.startVec = '0; e.isDone = 1'b1;
      e.round = RW'(ROUNDS - 1); e.memSel = 3'd0;
      sbq.push_back(e);
    end
  endtask

  task automatic drain(input int budget, input int restartCyc);
    int n;
    n = 0;
    while ((sbq.size() != 0) && (n < budget)) begin
      startA = (cyc == restartCyc);
      tick();
      startA = 1'b0;
      n++;
    end
    if (sbq.size() != 0) begin
      nVec++;
      nFail++;
      $display("FAIL drain_timeout: %0d events outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic runVec(input runVec_t v);
    for (int k = 0; k < NSTEPS; k++) curDly[k] = v.dly[k];
    beginRun();
    strayCyc = v.strayCyc;
    strayMask = v.strayMask;
    startA = 1'b1;
    pushRun(NSTEPS * ROUNDS, 1'b1);
    tick();
    startA = 1'b0;
    drain(400, v.restartCyc);
    chk("done_cycle", doneCyc, v.expDone);
    chk("memsel2_cycles", memSel2Cnt, 2 * (int'(v.dly[1]) + 2));
    tick();
    chk("post_done_mem_sel", int'(memSelA), 0);
    chk("post_done_busy", int'(busyA), 0);
    chk("post_done_round_idx", int'(roundIdxA), 0);
    strayCyc = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    sbEv_t e;
    int launch3Cyc, idleHits;
    nVec = 0; nFail = 0; cyc = 0; monOn = 0;
    rst = 1'b1;
    startA = 1'b0; abortA = 1'b0; startB = 1'b0; abortB = 1'b0;
    stepDoneA = '0; stepDoneB = '0; prevStartB = '0;
    strayCyc = -1; strayMask = '0;
    setDly(1, 1, 1, 1, 1);
    clearModels();

    tbl[0] = mk(1, 1,  1, 1, 1, -1, 5'b00000, -1,  31);
    tbl[1] = mk(1, 40, 1, 1, 1, -1, 5'b00000, -1, 109);
    tbl[2] = mk(1, 1,  1, 1, 1,  5, 5'b10000, 12,  31);
    tbl[3] = mk(2, 1,  3, 1, 1, -1, 5'b00000, -1,  37);
    tbl[4] = mk(1, 1,  1, 1, 5,  8, 5'b00001, -1,  39);

    for (int i = 0; i < 5; i++) begin
      doReset();
      runVec(tbl[i]);
    end

    // Abort while step 2 of round 0 waits on a slow engine.
    doReset();
    setDly(1, 1, 10, 1, 1);
    beginRun();
    startA = 1'b1;
    pushRun(3, 1'b0);
    tick();
    startA = 1'b0;
    while (cyc < 9) tick();
    abortA = 1'b1;
    tick();
    abortA = 1'b0;
    chk("abort_busy", int'(busyA), 0);
    chk("abort_mem_sel", int'(memSelA), 0);
    chk("abort_done", int'(doneA), 0);
    chk("abort_step_start", int'(stepStartA), 0);
    chk("abort_events_left", sbq.size(), 0);
    idleHits = 0;
    repeat (12) begin
      tick();
      if (busyA || doneA || (stepStartA != '0)) idleHits++;
    end
    chk("abort_late_done_ignored", idleHits, 0);
    beginRun();
    startA = 1'b1;
    pushRun(1, 1'b0);
    tick();
    startA = 1'b0;
    chk("abort_restart_events_left", sbq.size(), 0);

    // Watchdog fault on dutB (WDW=4) when engine 3 never answers.
    doReset();
    cyc = 0;
    launch3Cyc = -1;
    startB = 1'b1;
    tick();
    startB = 1'b0;
    while ((errorB == 1'b0) && (cyc < 60)) begin
      if (stepStartB == 5'b01000) launch3Cyc = cyc;
      tick();
    end
    chk("fault_launch3_cycle", launch3Cyc, 10);
    chk("fault_cycle", cyc, 26);
    chk("fault_busy", int'(busyB), 0);
    chk("fault_mem_sel", int'(memSelB), 0);
    chk("fault_step_start", int'(stepStartB), 0);
    tick();
    tick();
    chk("fault_error_held", int'(errorB), 1);
    startB = 1'b1;
    tick();
    chk("fault_clear_error", int'(errorB), 0);
    chk("fault_clear_busy", int'(busyB), 0);
    chk("fault_clear_no_launch", int'(stepStartB), 0);
    tick();
    startB = 1'b0;
    chk("fault_relaunch_step_start", int'(stepStartB), 1);
    chk("fault_relaunch_round_idx", int'(roundIdxB), 0);
    chk("fault_relaunch_mem_sel", int'(memSelB), 1);

    // Reset in ADVANCE of round 1, then a fresh run with nominal timing.
    doReset();
    setDly(1, 1, 1, 1, 1);
    beginRun();
    startA = 1'b1;
    pushRun(6, 1'b0);
    tick();
    startA = 1'b0;
    while (cyc < 18) tick();
    chk("pre_rst_round_idx", int'(roundIdxA), 1);
    chk("pre_rst_mem_sel", int'(memSelA), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_step_start", int'(stepStartA), 0);
    chk("midrun_rst_mem_sel", int'(memSelA), 0);
    chk("midrun_rst_round_idx", int'(roundIdxA), 0);
    chk("midrun_rst_busy", int'(busyA), 0);
    chk("midrun_rst_done", int'(doneA), 0);
    chk("midrun_rst_events_left", sbq.size(), 0);
    runVec(tbl[0]);

    // start held high through FINISH relaunches from IDLE, not back-to-back.
    doReset();
    setDly(1, 1, 1, 1, 1);
    beginRun();
    startA = 1'b1;
    pushRun(NSTEPS * ROUNDS, 1'b1);
    e.cyc = 33; e.startVec = 5'b00001; e.isDone = 1'b0; e.round = '0; e.memSel = 3'd1;
    sbq.push_back(e);
    while ((sbq.size() != 0) && (cyc < 60)) begin
      tick();
      if (cyc == 32) begin
        chk("held_idle_busy", int'(busyA), 0);
        chk("held_idle_step_start", int'(stepStartA), 0);
      end
    end
    chk("held_relaunch_cycle", cyc, 33);
    startA = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
